// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   INST_WIDTH / PC_WIDTH : default instruction and PC widths
//   PC_STEP               : byte increment between sequential fetches
//   fq_state_e            : fetch FSM state encoding
//   fifo_cnt_w()          : occupancy counter width for a given FIFO depth
package fetch_queue_pkg;

  localparam int INST_WIDTH = 32;
  localparam int PC_WIDTH   = 64;
  localparam int PC_STEP    = 4;

  typedef enum logic [1:0] {
    FQ_IDLE    = 2'd0,
    FQ_WAIT    = 2'd1,
    FQ_DISCARD = 2'd2
  } fq_state_e;

  // One extra bit so that "full" (count == depth) is representable.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Small synchronous FIFO holding {pc, instruction} entries for the fetch queue.
// The head entry is read asynchronously from a register array, so a word
// written at edge N is presentable in cycle N+1.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset (clears data too)
//   push, push_data    write an entry (ignored when full unless popping)
//   pop                remove the head entry (ignored when empty)
//   flush              empty the FIFO; has priority over push and pop
//   head_data          current head entry
//   count              number of valid entries (0..DEPTH)
module fetch_queue_sync_fifo
  import fetch_queue_pkg::*;
#(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             head_data,
  output logic [fifo_cnt_w(DEPTH)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = fifo_cnt_w(DEPTH);

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

  // Storage is reset so the presented head reads as zero out of reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          mem_reg[gi] <= '0;
        end else if (!flush && do_push && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage feeding the IF/ID register.
// Owns the fetch PC, issues one word read at a time to a variable-latency
// instruction memory, queues returned words with their PCs and presents them
// to decode with valid/ready. A taken branch (redirect) flushes the queue,
// reloads the fetch PC and drops any response still in flight.
// Optional build macro: FETCH_QUEUE_BYPASS_EN -- when the queue is empty, an
// accepted memory response is presented to decode in the same cycle.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   redirect_valid, redirect_pc   branch taken / target (low two bits ignored)
//   imem_req, imem_addr           read request, address stable until ack
//   imem_ack, imem_rdata          read response
//   id_valid, id_ready            decode handshake
//   id_pc, id_instruction         presented entry
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = PC_WIDTH,
  parameter int                INST_W   = INST_WIDTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_instruction
);

  localparam int CNT_W   = fifo_cnt_w(DEPTH);
  localparam int ENTRY_W = ADDR_W + INST_W;

  fq_state_e           state_reg;
  logic                imem_req_reg;
  logic [ADDR_W-1:0]   fetch_pc_reg;
  logic [ADDR_W-1:0]   redirect_pc_aligned;
  logic                ack_accept;
  logic                has_room;
  logic                fifo_push;
  logic                fifo_pop;
  logic [CNT_W-1:0]    fifo_count;
  logic [ENTRY_W-1:0]  fifo_head;

  assign redirect_pc_aligned = redirect_pc & ~ADDR_W'(3);

  // A response is kept only in WAIT and only when no redirect lands with it.
  assign ack_accept = (state_reg == FQ_WAIT) && imem_ack && !redirect_valid;

  // Checked at issue time: with a single outstanding request, the response
  // can never find the queue full.
  assign has_room = fifo_count < CNT_W'(DEPTH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= FQ_IDLE;
      imem_req_reg <= 1'b0;
      fetch_pc_reg <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_reg <= redirect_pc_aligned;
      imem_req_reg <= 1'b0;
      case (state_reg)
        // The outstanding response must still be swallowed unless it is
        // arriving right now.
        FQ_WAIT:    state_reg <= imem_ack ? FQ_IDLE : FQ_DISCARD;
        FQ_DISCARD: state_reg <= imem_ack ? FQ_IDLE : FQ_DISCARD;
        default:    state_reg <= FQ_IDLE;
      endcase
    end else begin
      case (state_reg)
        FQ_IDLE: begin
          if (has_room) begin
            state_reg    <= FQ_WAIT;
            imem_req_reg <= 1'b1;
          end
        end
        FQ_WAIT: begin
          if (imem_ack) begin
            state_reg    <= FQ_IDLE;
            imem_req_reg <= 1'b0;
            fetch_pc_reg <= fetch_pc_reg + ADDR_W'(PC_STEP);
          end
        end
        FQ_DISCARD: begin
          if (imem_ack) state_reg <= FQ_IDLE;
        end
        default: begin
          state_reg    <= FQ_IDLE;
          imem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_reg;
  assign imem_addr = fetch_pc_reg;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_hit;

  // Empty queue: hand the response straight to decode; store it only if
  // decode does not take it this cycle.
  assign bypass_hit     = ack_accept && (fifo_count == '0);
  assign fifo_push      = ack_accept && !(bypass_hit && id_ready);
  assign fifo_pop       = id_ready && !bypass_hit;
  assign id_valid       = bypass_hit || (fifo_count != '0);
  assign id_pc          = bypass_hit ? fetch_pc_reg : fifo_head[ENTRY_W-1:INST_W];
  assign id_instruction = bypass_hit ? imem_rdata   : fifo_head[INST_W-1:0];
`else
  assign fifo_push      = ack_accept;
  assign fifo_pop       = id_ready;
  assign id_valid       = (fifo_count != '0);
  assign id_pc          = fifo_head[ENTRY_W-1:INST_W];
  assign id_instruction = fifo_head[INST_W-1:0];
`endif

  fetch_queue_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data ({fetch_pc_reg, imem_rdata}),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a latency-programmable memory model answers
// requests, a monitor logs every decode handshake and every accepted memory
// handshake, and the main sequence compares them against hand-derived values.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_instruction;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    int          cyc;
  } ent_t;

  ent_t        got_q[$];
  logic [63:0] req_log[$];

  int          mem_lat = 1;
  bit          mem_pend = 1'b0;
  int          mem_wait = 0;
  logic [63:0] mem_addr = '0;

  fetch_queue dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instruction (id_instruction)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    if (a == 64'h400) return 32'h8B02_0020;
    return a[31:0] ^ 32'hDEAD_0000;
  endfunction

  // Memory: a request seen while idle is answered in its mem_lat-th cycle;
  // the response still comes even if the request is withdrawn meanwhile.
  always @(posedge clk) begin
    #1;
    imem_ack = 1'b0;
    if (!reset_n) begin
      mem_pend = 1'b0;
    end else begin
      if (!mem_pend && imem_req) begin
        mem_pend = 1'b1;
        mem_wait = mem_lat;
        mem_addr = imem_addr;
      end
      if (mem_pend) begin
        if (mem_wait <= 1) begin
          imem_ack   = 1'b1;
          imem_rdata = inst_of(mem_addr);
          mem_pend   = 1'b0;
        end else begin
          mem_wait--;
        end
      end
    end
  end

  // Handshakes are sampled mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    if (reset_n && id_valid && id_ready) begin
      got_q.push_back('{pc: id_pc, inst: id_instruction, cyc: cyc});
      $display("[%0d] decode takes pc=%h inst=%h", cyc, id_pc, id_instruction);
    end
    if (reset_n && imem_req && imem_ack) req_log.push_back(imem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
    got_q.delete();
    req_log.delete();
  endtask

  initial begin
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_req", 64'(imem_req), 64'd0);
    check_eq("rst_addr", imem_addr, 64'd0);
    check_eq("rst_valid", 64'(id_valid), 64'd0);
    check_eq("rst_pc", id_pc, 64'd0);
    check_eq("rst_inst", 64'(id_instruction), 64'd0);

    // Streaming with 1-cycle memory and decode always ready
    reset_n  = 1'b1;
    id_ready = 1'b1;
    for (int i = 0; i < 40 && got_q.size() < 4; i++) tick();
    check_eq("t1_timeout", 64'(got_q.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++) check_eq("t1_pc", got_q[i].pc, 64'(4 * i));
    check_eq("t1_inst0", 64'(got_q[0].inst), 64'hDEAD_0000);
    check_eq("t1_spacing", 64'(got_q[1].cyc - got_q[0].cyc), 64'd2);

    // Decode stalled: queue fills with 0..C, then requests stop
    id_ready = 1'b0;
    redirect_to(64'h0);
    repeat (30) tick();
    check_eq("t2_nreq", 64'(req_log.size()), 64'd4);
    check_eq("t2_lastreq", req_log[3], 64'hC);
    check_eq("t2_req_off", 64'(imem_req), 64'd0);
    check_eq("t2_valid", 64'(id_valid), 64'd1);
    check_eq("t2_head_pc", id_pc, 64'h0);
    check_eq("t2_head_inst", 64'(id_instruction), 64'(inst_of(64'h0)));
    id_ready = 1'b1;
    for (int i = 0; i < 20 && req_log.size() < 5; i++) tick();
    check_eq("t2_resume", req_log[4], 64'h10);
    for (int i = 0; i < 20 && got_q.size() < 5; i++) tick();
    for (int i = 0; i < 5; i++) check_eq("t2_order", got_q[i].pc, 64'(4 * i));

    // Redirect while the request to 0x8 has been pending three cycles
    mem_lat = 5;
    redirect_to(64'h8);
    for (int i = 0; i < 10 && !(imem_req && imem_addr == 64'h8); i++) tick();
    check_eq("t3_req8", 64'(imem_req && imem_addr == 64'h8), 64'd1);
    tick();
    tick();
    redirect_to(64'h100);
    check_eq("t3_discard_req", 64'(imem_req), 64'd0);
    check_eq("t3_flushed", 64'(id_valid), 64'd0);
    for (int i = 0; i < 40 && got_q.size() < 1; i++) tick();
    check_eq("t3_pc", got_q[0].pc, 64'h100);
    check_eq("t3_inst", 64'(got_q[0].inst), 64'(inst_of(64'h100)));

    // Redirect in the same cycle as an ack
    mem_lat = 3;
    redirect_to(64'h200);
    for (int i = 0; i < 20 && !(imem_ack && imem_req && imem_addr == 64'h200); i++) tick();
    check_eq("t4_ack200", 64'(imem_ack && imem_req && imem_addr == 64'h200), 64'd1);
    redirect_to(64'h300);
    check_eq("t4_empty", 64'(id_valid), 64'd0);
    check_eq("t4_idle", 64'(imem_req), 64'd0);
    tick();
    check_eq("t4_req", 64'(imem_req), 64'd1);
    check_eq("t4_addr", imem_addr, 64'h300);
    for (int i = 0; i < 20 && got_q.size() < 1; i++) tick();
    check_eq("t4_pc", got_q[0].pc, 64'h300);

    // PC wrap at the top of the address space (target misaligned on purpose)
    mem_lat = 1;
    redirect_to(64'hFFFF_FFFF_FFFF_FFFE);
    for (int i = 0; i < 20 && got_q.size() < 2; i++) tick();
    check_eq("t5_pc_top", got_q[0].pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("t5_pc_wrap", got_q[1].pc, 64'h0);
    check_eq("t5_req_top", req_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("t5_req_wrap", req_log[1], 64'h0);

    // Empty queue, ack with decode ready: presentation latency
    mem_lat = 2;
    redirect_to(64'h400);
    for (int i = 0; i < 20 && !(imem_ack && imem_req); i++) tick();
    check_eq("t6_ack", 64'(imem_ack && imem_req), 64'd1);
`ifdef FETCH_QUEUE_BYPASS_EN
    check_eq("t6_byp_valid", 64'(id_valid), 64'd1);
    check_eq("t6_byp_pc", id_pc, 64'h400);
    check_eq("t6_byp_inst", 64'(id_instruction), 64'h8B02_0020);
    tick();
    check_eq("t6_byp_nostore", 64'(id_valid), 64'd0);
`else
    check_eq("t6_nobyp_valid", 64'(id_valid), 64'd0);
    tick();
    check_eq("t6_valid", 64'(id_valid), 64'd1);
    check_eq("t6_pc", id_pc, 64'h400);
    check_eq("t6_inst", 64'(id_instruction), 64'h8B02_0020);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
